// File: rtl/psp_mem_pkg.sv
// Shared types and constants for the psp main-memory arbiter.
package psp_mem_pkg;

    localparam int PSP_ADDR_WIDTH = 32;
    localparam int PSP_DATA_WIDTH = 32;
    localparam int PSP_BE_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [PSP_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [PSP_BE_WIDTH-1:0]   be;
        logic [PSP_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // Reads enable every byte lane; writes use the requester's byte enables.
    function automatic logic [PSP_BE_WIDTH-1:0] issue_data_en(input mem_req_t r);
        return r.we ? r.be : {PSP_BE_WIDTH{1'b1}};
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant picker for the two memory requesters.
// Build option PSP_MEM_ARB_ROUND_ROBIN_EN selects round-robin, otherwise req0 has fixed priority.
module mem_arb_picker (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

`ifdef PSP_MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        // A tie goes to whoever did not win the previous acceptance.
        if (&valid_i) begin
            grant_id_o = ~last_grant_i;
        end else begin
            grant_id_o = valid_i[1];
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_id_o = ~valid_i[0] & valid_i[1];
    end
`endif

    assign grant_o = (|valid_i) ? (grant_id_o ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one main-memory port: one transaction at a time,
// IDLE -> ISSUE -> (WAIT) -> RESP sequencing to cover the memory read latency.
module mem_arbiter
    import psp_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic                    req0_we,
    input  logic [DATA_WIDTH/8-1:0] req0_be,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    output logic                    rsp0_valid,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic                    req1_we,
    input  logic [DATA_WIDTH/8-1:0] req1_be,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [DATA_WIDTH/8-1:0] mem_data_en,
    output logic                    mem_write_en
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    arb_state_t state_q, state_d;
    mem_req_t   req_q, req_d;
    logic       gid_q, gid_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] grant;
    logic       grant_id;
    logic       accept;

    mem_arb_picker u_picker (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_id_o   (grant_id)
    );

    assign accept = (state_q == IDLE) && (|grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            gid_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.addr   = grant_id ? PSP_ADDR_WIDTH'(req1_addr)  : PSP_ADDR_WIDTH'(req0_addr);
                    req_d.we     = grant_id ? req1_we : req0_we;
                    req_d.be     = grant_id ? PSP_BE_WIDTH'(req1_be)      : PSP_BE_WIDTH'(req0_be);
                    req_d.wdata  = grant_id ? PSP_DATA_WIDTH'(req1_wdata) : PSP_DATA_WIDTH'(req0_wdata);
                    gid_d        = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = (MEM_LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                // Leaves on the cycle the counter reads 1, giving MEM_LATENCY-1 WAIT cycles.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req0_ready   = (state_q == IDLE) && grant[0] && !rst;
        req1_ready   = (state_q == IDLE) && grant[1] && !rst;
        mem_addr     = ADDR_WIDTH'(req_q.addr);
        mem_wdata    = DATA_WIDTH'(req_q.wdata);
        mem_write_en = 1'b0;
        mem_data_en  = '0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        rsp0_rdata   = '0;
        rsp1_rdata   = '0;
        case (state_q)
            ISSUE: begin
                mem_write_en = req_q.we;
                mem_data_en  = (DATA_WIDTH/8)'(issue_data_en(req_q));
            end
            RESP: begin
                if (gid_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = req_q.we ? '0 : mem_rdata;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = req_q.we ? '0 : mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expectations from a
// word-level memory model; a negedge monitor checks the memory port and responses.
module tb_mem_arbiter;

    localparam int LAT = 3;
    localparam int MW  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [3:0]  req0_be = '0, req1_be = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_data_en;
    logic        mem_write_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          id;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  en;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    bit          busy = 0;
    bit          last_id = 1;
    bit          grant_log[$];
    int          acc_log[$];
    logic [31:0] ref_mem [MW];
    logic [31:0] phys    [MW];
    logic [31:0] rd_pipe [LAT];

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_we(req0_we), .req0_be(req0_be), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_be(req1_be), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_data_en(mem_data_en), .mem_write_en(mem_write_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            8:       return 32'hAAAAAAAA;
            12:      return 32'h00000055;
            default: return (i * 32'h01030507) ^ 32'hC0DE0000;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Stand-in for main_mem port B: byte-enabled write, read data after LAT edges.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) phys[i] <= init_word(i);
        end else if (mem_write_en) begin
            phys[mem_addr[7:2]] <= merge(phys[mem_addr[7:2]], mem_wdata, mem_data_en);
        end
        rd_pipe[0] <= phys[mem_addr[7:2]];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy    = 0;
            last_id = 1;
            if (preload) for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
        end else begin
            exp_t e;
            chk("ready_exclusive", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (busy) chk("ready_while_busy", {62'd0, req1_ready, req0_ready}, 64'd0);
            else      chk("ready_when_idle", {63'd0, req0_ready | req1_ready}, {63'd0, req0_valid | req1_valid});
            if (busy && cyc == exp_q[0].acc + 1) begin
                chk("issue_addr", {32'd0, mem_addr}, {32'd0, exp_q[0].addr});
                chk("issue_we", {63'd0, mem_write_en}, {63'd0, exp_q[0].we});
                chk("issue_en", {60'd0, mem_data_en}, {60'd0, exp_q[0].en});
            end else begin
                chk("idle_port", {59'd0, mem_write_en, mem_data_en}, 64'd0);
            end
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    busy = 0;
                    chk("rsp_id", {62'd0, rsp1_valid, rsp0_valid}, e.id ? 64'd2 : 64'd1);
                    chk("rsp_cycle", 64'(cyc), 64'(e.acc + 1 + LAT));
                    chk("rsp_rdata", {32'd0, e.id ? rsp1_rdata : rsp0_rdata}, {32'd0, e.rdata});
                    $display("rsp id=%0d we=%0d addr=%0h rdata=%0h cyc=%0d", e.id, e.we, e.addr,
                             e.id ? rsp1_rdata : rsp0_rdata, cyc);
                end
            end else if (busy && cyc > exp_q[0].acc + 1 + LAT) begin
                chk("rsp_missing", 64'd0, 64'd1);
                exp_q.delete();
                busy = 0;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                e.id = req1_valid && req1_ready;
                if (req0_valid && req1_valid) begin
`ifdef PSP_MEM_ARB_ROUND_ROBIN_EN
                    chk("tie_grant", {63'd0, e.id}, {63'd0, ~last_id});
`else
                    chk("tie_grant", {63'd0, e.id}, 64'd0);
`endif
                end
                e.we    = e.id ? req1_we : req0_we;
                e.addr  = e.id ? req1_addr : req0_addr;
                e.en    = e.we ? (e.id ? req1_be : req0_be) : 4'hF;
                e.acc   = cyc;
                if (e.we) begin
                    ref_mem[e.addr[7:2]] = merge(ref_mem[e.addr[7:2]], e.id ? req1_wdata : req0_wdata, e.en);
                    e.rdata = 32'd0;
                end else begin
                    e.rdata = ref_mem[e.addr[7:2]];
                end
                exp_q.push_back(e);
                grant_log.push_back(e.id);
                acc_log.push_back(cyc);
                busy    = 1;
                last_id = e.id;
            end
        end
    end

    task automatic do_req(input bit id, input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        bit done;
        done = 0;
        if (id) begin
            req1_addr = addr; req1_we = we; req1_be = be; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_addr = addr; req0_we = we; req0_be = be; req0_wdata = wd; req0_valid = 1'b1;
        end
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50 && busy; n++) @(negedge clk);
        if (busy) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_requester(input bit id, input int count);
        int g;
        for (int i = 0; i < count; i++) begin
            g = $urandom_range(0, 3);
            repeat (g) @(posedge clk);
            if (g != 0) #1;
            do_req(id, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                   4'($urandom), $urandom);
        end
    endtask

    initial begin
        bit exp_g;
        bit lst;
        int r0, r1, base;
        req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_memport", {27'd0, mem_write_en, mem_data_en, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid, rsp0_rdata | rsp1_rdata}, 64'd0);
        req0_valid = 1'b0;
        preload    = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;

        do_req(1, 0, 32'h10, 4'hF, 32'h0);
        wait_idle();
        do_req(0, 1, 32'h20, 4'b0011, 32'h11223344);
        wait_idle();
        do_req(0, 0, 32'h20, 4'h0, 32'h0);
        wait_idle();
        do_req(0, 1, 32'h30, 4'h0, 32'hFFFFFFFF);
        wait_idle();
        do_req(0, 0, 32'h30, 4'h0, 32'h0);
        req1_valid = 1'b1;
        req1_addr  = 32'h10;
        req1_we    = 1'b0;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_idle();

        // Contention: both requesters hold valid for four reads each.
        base = grant_log.size();
        lst  = last_id;
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(0, 0, {26'd0, 4'(i), 2'b00}, 4'h0, 32'h0);
            end
            begin
                for (int i = 0; i < 4; i++) do_req(1, 0, {26'd0, 4'(i + 8), 2'b00}, 4'h0, 32'h0);
            end
        join
        wait_idle();
        r0 = 4;
        r1 = 4;
        for (int k = 0; k < 8; k++) begin
`ifdef PSP_MEM_ARB_ROUND_ROBIN_EN
            exp_g = (r0 > 0 && r1 > 0) ? ~lst : (r0 == 0);
`else
            exp_g = (r0 == 0);
`endif
            if (exp_g) r1--; else r0--;
            lst = exp_g;
            if (base + k < grant_log.size()) begin
                chk("contention_grant", {63'd0, grant_log[base + k]}, {63'd0, exp_g});
                if (k > 0) chk("contention_spacing", 64'(acc_log[base + k] - acc_log[base + k - 1]), 64'(2 + LAT));
            end else begin
                chk("contention_count", 64'(grant_log.size() - base), 64'd8);
            end
        end

        // Reset while the FSM sits in WAIT.
        do_req(0, 0, 32'h10, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_memport", {27'd0, mem_write_en, mem_data_en, mem_addr}, 64'd0);
        chk("midrst_rsp", {61'd0, rsp1_valid, rsp0_valid, req0_ready | req1_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(1, 0, 32'h20, 4'h0, 32'h0);
        wait_idle();

        fork
            rand_requester(0, 20);
            rand_requester(1, 20);
        join
        wait_idle();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 64'd0, 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one main-memory port (addr, data_i, data_o, 4-bit data_en byte enables, write_en) between two requesters: req0 (data cache) and req1 (instruction cache).
- Sits between the cache refill/writeback paths and main_mem port B in psp.
- Handles one transaction at a time with a valid/ready request handshake and a single-cycle response pulse.
- Sequences memory read latency with a small FSM.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8.
- MEM_LATENCY, 1, cycles from the memory sampling edge to read data valid on mem_rdata; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has a request.
- reqN_ready  out  1  request accepted this cycle when valid && ready.
- reqN_addr  in  ADDR_WIDTH  byte address.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_be  in  DATA_WIDTH/8  byte enables for a write.
- reqN_wdata  in  DATA_WIDTH  write data.
- rspN_valid  out  1  one-cycle completion pulse for reads and writes.
- rspN_rdata  out  DATA_WIDTH  read data; meaningful only while rspN_valid=1 for a read.
- mem_addr  out  ADDR_WIDTH  drives memory addr.
- mem_wdata  out  DATA_WIDTH  drives memory data_i.
- mem_rdata  in  DATA_WIDTH  from memory data_o.
- mem_data_en  out  DATA_WIDTH/8  drives memory data_en.
- mem_write_en  out  1  drives memory write_en.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values (asynchronous, take effect immediately): all outputs 0, latency counter 0, request registers 0, last_grant=1 (so req0 wins first).
- Acceptance: only in IDLE.
  - Grant is computed combinationally from the valid inputs.
  - reqN_ready=1 only for the granted requester, only in IDLE; the non-granted ready is 0.
  - On valid && ready: latch addr/we/be/wdata and the grant id; go to ISSUE.
- ISSUE (one cycle): drive the latched request on the memory port.
  - mem_write_en = latched we.
  - mem_data_en = latched be for a write, all ones for a read.
  - The memory samples at the end of ISSUE.
  - Next state: WAIT if MEM_LATENCY>1, else RESP. Load the counter with MEM_LATENCY-1.
- WAIT: mem_write_en=0 and mem_data_en=0; hold mem_addr. Decrement the counter; go to RESP when it reaches 1.
- RESP (one cycle): rspG_valid=1 for the granted id only.
  - rspG_rdata = mem_rdata (passthrough) for a read; 0 for a write.
  - Next state: IDLE.
- Latency: accept at cycle t, rsp at t+1+MEM_LATENCY. Minimum spacing between acceptances is 2+MEM_LATENCY cycles.
- Outside ISSUE: mem_write_en=0 and mem_data_en=0, so no spurious writes.
- Write with be=0: the ISSUE cycle drives data_en=0 (memory unchanged); still acked via rsp.
- Simultaneous valid on both requesters: one is granted per the arbitration policy. The loser keeps valid asserted and must hold its request stable until ready.
- Requester drops valid without ready: nothing happens, no state change.
- Reset mid-transaction: FSM returns to IDLE asynchronously and any pending response is dropped (no rsp pulse). If rst asserts during ISSUE, mem_write_en falls immediately and the write is not guaranteed.
- Arbitration (default, macro undefined): fixed priority, req0 over req1. req1 can starve; this is accepted.

Optional Feature:
- Macro: PSP_MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. On simultaneous valid, grant the requester that is not last_grant. last_grant updates on every acceptance; reset value 1, so req0 wins the first tie.
- Undefined: fixed priority req0; last_grant register optimised away.

Decomposition:
- Package psp_mem_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - PSP_ADDR_WIDTH=32, PSP_DATA_WIDTH=32, PSP_BE_WIDTH=4.
  - mem_req_t packed struct {addr, we, be, wdata}.
- One sub-module: mem_arb_picker, combinational. Inputs: valid[1:0], last_grant. Outputs: grant one-hot and grant_id. The macro is evaluated only inside this sub-module.

Test Plan:
- Single read (MEM_LATENCY=1), memory preloaded 0xDEADBEEF at 0x10: req1 read 0x10 at cycle t -> req1_ready=1 at t; mem_addr=0x10, mem_write_en=0, data_en=4'hF at t+1; rsp1_valid=1 with rdata=0xDEADBEEF at t+2; rsp0_valid stays 0.
- Byte write then read: req0 write 0x20, be=4'b0011, wdata=0x11223344 over 0xAAAAAAAA -> rsp0 pulse at t+2 with rdata=0; a subsequent read of 0x20 returns 0xAAAA3344.
- Contention, both valid continuously with 4 reads each:
  - Without macro: grants are 0,0,0,0, then 1s.
  - With PSP_MEM_ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1,...
  - In both cases each acceptance is 3 cycles apart.
- MEM_LATENCY=3: read accepted at t -> WAIT occupies t+2,t+3; rsp at t+4; no ready asserted for either requester during t+1..t+4.
- Reset in WAIT (MEM_LATENCY=3): assert rst at t+2 -> all outputs 0 immediately, no rsp pulse; after release, the first request is accepted on the first IDLE cycle.
- Write with be=0 to 0x30 holding 0x55: mem_data_en=0 during ISSUE, memory still 0x55, rsp0_valid pulses once.
